// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the multi-cycle core: opcodes, FSM states, ALU ops, trap causes.
// Pure declarations and combinational helpers; no latency.
// No flow control here; callers own all handshakes.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef logic [2:0] state_t;
    localparam state_t ST_FETCH = 3'd0;
    localparam state_t ST_EXEC  = 3'd1;
    localparam state_t ST_MEM   = 3'd2;
    localparam state_t ST_WB    = 3'd3;
    localparam state_t ST_HALT  = 3'd4;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {TRAP_NONE, TRAP_ILLEGAL, TRAP_MISALIGN, TRAP_ECALL} trap_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] ir);
        case (ir[6:0])
            OP_LUI, OP_AUIPC: return {ir[31:12], 12'b0};
            OP_JAL:           return {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            OP_BRANCH:        return {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_STORE:         return {{21{ir[31]}}, ir[30:25], ir[11:7]};
            default:          return {{21{ir[31]}}, ir[30:20]};
        endcase
    endfunction

    // ir[30] only selects SUB for register ops; immediate ops use it solely for SRAI.
    function automatic alu_op_t alu_decode(input logic is_reg, input logic [2:0] f3, input logic f7b5);
        case (f3)
            3'd0:    return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return f7b5 ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] alu_exec(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a + b;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Load/store lane steering: byte enables, replicated store data, load extract/extend, misalign flag.
// Purely combinational, zero latency.
// No backpressure; outputs follow inputs.
module riscv_lsu_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);
    logic [31:0] lane;

    always_comb begin
        lane = rdata >> {offset, 3'b000};
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << offset;
                wdata      = {4{store_data[7:0]}};
                load_data  = funct3[2] ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
                misaligned = 1'b0;
            end
            2'b01: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                load_data  = funct3[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
                misaligned = offset[0];
            end
            default: begin
                be         = 4'b1111;
                wdata      = store_data;
                load_data  = rdata;
                misaligned = (offset != 2'b00);
            end
        endcase
    end
endmodule

// File: rtl/riscv_multi_cycle_core.sv
// RV32I multi-cycle core with req/ack instruction and data buses and a sticky HALT/trap state.
// Zero-wait latency: 3 cycles ALU/branch/jump, 4 cycles load/store; each wait cycle adds one.
// Requests are held with stable address/data until ack; no other stalling source.
module riscv_multi_cycle_core
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          HALT_ON_EC = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  trap_cause
);
    state_t      state;
    logic [31:0] pc, ir, next_pc_q, wb_val;
    logic        wb_we, imem_req_q, dmem_req_q;
    trap_t       cause;
    dmem_req_t   dreq;
    logic [31:0] rf [32];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] rs1_val, rs2_val, imm, alu_res, ea, target, rd_val;
    logic        rd_we, is_mem, illegal, is_ec;
    trap_t       trap;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_wdata, lsu_load;
    logic        lsu_mis;

    assign opcode  = ir[6:0];
    assign rd      = ir[11:7];
    assign f3      = ir[14:12];
    assign rs1_val = rf[ir[19:15]];
    assign rs2_val = rf[ir[24:20]];

    always_comb begin
        imm     = imm_gen(ir);
        alu_res = alu_exec(alu_decode(opcode == OP_REG, f3, ir[30]), rs1_val,
                           (opcode == OP_REG) ? rs2_val : imm);
        ea      = rs1_val + imm;
        target  = pc + 32'd4;
        rd_val  = alu_res;
        rd_we   = 1'b0;
        is_mem  = 1'b0;
        illegal = 1'b0;
        is_ec   = 1'b0;
        case (opcode)
            OP_LUI:    begin rd_we = 1'b1; rd_val = imm; end
            OP_AUIPC:  begin rd_we = 1'b1; rd_val = pc + imm; end
            OP_JAL:    begin rd_we = 1'b1; rd_val = pc + 32'd4; target = pc + imm; end
            OP_JALR:   begin rd_we = 1'b1; rd_val = pc + 32'd4; target = ea & ~32'd1; end
            OP_BRANCH: begin
                illegal = (f3[2:1] == 2'b01);
                if (br_taken(f3, rs1_val, rs2_val)) target = pc + imm;
            end
            OP_LOAD:   begin rd_we = 1'b1; is_mem = 1'b1; illegal = (f3[1:0] == 2'b11) || (f3[2] && f3[1]); end
            OP_STORE:  begin is_mem = 1'b1; illegal = (f3 > 3'd2); end
            OP_IMM, OP_REG: rd_we = 1'b1;
            OP_FENCE:  ;
            OP_SYSTEM: is_ec = HALT_ON_EC;
            default:   illegal = 1'b1;
        endcase
        if (illegal)                              trap = TRAP_ILLEGAL;
        else if (target[1] || (is_mem && lsu_mis)) trap = TRAP_MISALIGN;
        else if (is_ec)                            trap = TRAP_ECALL;
        else                                       trap = TRAP_NONE;
    end

    // Registers are untouched until WB, so ea stays valid through MEM for load extraction.
    riscv_lsu_align u_lsu (
        .funct3     (f3),
        .offset     (ea[1:0]),
        .store_data (rs2_val),
        .rdata      (dmem_rdata),
        .be         (lsu_be),
        .wdata      (lsu_wdata),
        .load_data  (lsu_load),
        .misaligned (lsu_mis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (state == ST_WB && wb_we) begin
            rf[rd] <= wb_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            ir         <= NOP;
            next_pc_q  <= '0;
            wb_val     <= '0;
            wb_we      <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            cause      <= TRAP_NONE;
            dreq       <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ack) begin
                        imem_req_q <= 1'b0;
                        ir         <= imem_rdata;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (trap != TRAP_NONE) begin
                        cause <= trap;
                        state <= ST_HALT;
                    end else begin
                        next_pc_q <= target;
                        wb_we     <= rd_we && (rd != 5'd0);
                        wb_val    <= rd_val;
                        if (is_mem) begin
                            dreq.we    <= (opcode == OP_STORE);
                            dreq.be    <= lsu_be;
                            dreq.addr  <= {ea[31:2], 2'b00};
                            dreq.wdata <= lsu_wdata;
                            dmem_req_q <= 1'b1;
                            state      <= ST_MEM;
                        end else begin
                            state <= ST_WB;
                        end
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        if (!dreq.we) wb_val <= lsu_load;
                        state <= ST_WB;
                    end
                end
                ST_WB: begin
                    pc         <= next_pc_q;
                    imem_req_q <= 1'b1;
                    state      <= ST_FETCH;
                end
                ST_HALT: ;
                default: state <= ST_HALT;
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_req_q & dreq.we;
    assign dmem_be    = dmem_req_q ? dreq.be : 4'b0000;
    assign dmem_addr  = dreq.addr;
    assign dmem_wdata = dreq.wdata;
    assign pc_out     = pc;
    assign instr_out  = ir;
    assign retire     = (state == ST_WB);
    assign halted     = (state == ST_HALT);
    assign trap_cause = cause;
endmodule

// File: tb/tb_riscv_multi_cycle_core.sv
// Directed bench for riscv_multi_cycle_core: bus responders with configurable waits and hand-computed checks.
module tb_riscv_multi_cycle_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        dmem_req, dmem_we, d_ack_resp = 1'b0, force_dack = 1'b0;
    wire         dmem_ack = d_ack_resp | force_dack;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic [31:0] pc_out, instr_out;
    logic        retire, halted;
    logic [1:0]  trap_cause;

    always #5 clk = ~clk;

    riscv_multi_cycle_core #(.RESET_PC(32'h0), .HALT_ON_EC(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .pc_out(pc_out), .instr_out(instr_out), .retire(retire), .halted(halted),
        .trap_cause(trap_cause)
    );

    logic [31:0] imem [64];
    logic [31:0] dmem [128];
    int  tests = 0, fails = 0, cyc = 0;
    int  iwait_fix = 0, dwait_fix = 0;
    bit  rand_wait = 0;

    int          i_cnt, i_wait, d_cnt, d_wait;
    bit          i_busy = 0, d_busy = 0;
    logic [31:0] i_addr0;
    logic [68:0] d_snap0;
    int          nret = 0, ndtx = 0, dreq_cyc = 0, glitch = 0;
    logic [31:0] ret_pc [512];
    int          ret_cyc [512];
    logic [31:0] tx_addr [512], tx_wd [512];
    logic [3:0]  tx_be [512];
    logic        tx_we [512];
    int          rb, xb, db, gb;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responders plus retire/transaction monitors, all sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            imem_ack = 1'b0; d_ack_resp = 1'b0; i_busy = 0; d_busy = 0;
            for (int k = 0; k < 128; k++) dmem[k] = '0;
        end else begin
            if (imem_req) begin
                if (!i_busy) begin
                    i_busy = 1; i_cnt = 0; i_addr0 = imem_addr;
                    i_wait = rand_wait ? int'($urandom_range(0, 5)) : iwait_fix;
                end else if (imem_addr !== i_addr0) glitch++;
                if (i_cnt == i_wait) begin
                    imem_ack = 1'b1; imem_rdata = imem[imem_addr[7:2]]; i_busy = 0;
                end else begin
                    imem_ack = 1'b0; i_cnt++;
                end
            end else begin
                if (i_busy) glitch++;
                imem_ack = 1'b0; i_busy = 0;
            end
            if (dmem_req) begin
                dreq_cyc++;
                if (!d_busy) begin
                    d_busy = 1; d_cnt = 0; d_snap0 = {dmem_we, dmem_be, dmem_addr, dmem_wdata};
                    d_wait = rand_wait ? int'($urandom_range(0, 5)) : dwait_fix;
                end else if ({dmem_we, dmem_be, dmem_addr, dmem_wdata} !== d_snap0) glitch++;
                if (d_cnt == d_wait) begin
                    d_ack_resp = 1'b1; d_busy = 0;
                    if (dmem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (dmem_be[b]) dmem[dmem_addr[8:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
                    end else dmem_rdata = dmem[dmem_addr[8:2]];
                    if (ndtx < 512) begin
                        tx_addr[ndtx] = dmem_addr; tx_wd[ndtx] = dmem_wdata;
                        tx_be[ndtx] = dmem_be; tx_we[ndtx] = dmem_we; ndtx++;
                    end
                end else begin
                    d_ack_resp = 1'b0; d_cnt++;
                end
            end else begin
                if (d_busy) glitch++;
                d_ack_resp = 1'b0; d_busy = 0;
            end
            if (retire && nret < 512) begin
                ret_pc[nret] = pc_out; ret_cyc[nret] = cyc; nret++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] i_t(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] s_t(input int imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        logic [31:0] v;
        v = imm;
        return {v[11:5], rs2, rs1, f3, v[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(input int imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] j_t(input int imm, input logic [4:0] rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd, 7'h6F};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        return i_t(imm, rs1, 3'd0, rd, 7'h13);
    endfunction

    localparam logic [31:0] ECALL = 32'h0000_0073;

    task automatic fill_imem();
        for (int k = 0; k < 64; k++) imem[k] = 32'h0000_007F;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rb = nret; xb = ndtx; db = dreq_cyc; gb = glitch;
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(input int budget, input string tag);
        int n = 0;
        while (!halted && n < budget) begin @(negedge clk); n++; end
        chk({tag, " halt reached"}, {31'b0, halted}, 32'd1);
    endtask

    task automatic prog_loop();
        fill_imem();
        imem[0]  = addi(5'd1, 5'd0, 32'h40);
        imem[1]  = addi(5'd2, 5'd0, 3);
        imem[2]  = addi(5'd3, 5'd0, 32'h11);
        imem[3]  = s_t(0, 5'd3, 5'd1, 3'd2);
        imem[4]  = i_t(0, 5'd1, 3'd2, 5'd4, 7'h03);
        imem[5]  = {7'b0, 5'd4, 5'd3, 3'd0, 5'd3, 7'h33};
        imem[6]  = addi(5'd1, 5'd1, 4);
        imem[7]  = addi(5'd2, 5'd2, -1);
        imem[8]  = b_t(-20, 5'd0, 5'd2, 3'd1);
        imem[9]  = s_t(0, 5'd3, 5'd1, 3'd2);
        imem[10] = ECALL;
    endtask

    task automatic chk_loop(input string tag);
        chk({tag, " m40"}, dmem[16], 32'h11);
        chk({tag, " m44"}, dmem[17], 32'h22);
        chk({tag, " m48"}, dmem[18], 32'h44);
        chk({tag, " m4c"}, dmem[19], 32'h88);
        chk({tag, " retires"}, nret - rb, 22);
        chk({tag, " addr/req stable"}, glitch - gb, 0);
    endtask

    initial begin
        // Test 1: reset state, addi chain, retire cadence, store latency, ECALL halt.
        fill_imem();
        imem[0] = addi(5'd1, 5'd0, 5);
        imem[1] = addi(5'd2, 5'd1, -7);
        imem[2] = s_t(32'h40, 5'd2, 5'd0, 3'd2);
        imem[3] = ECALL;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst imem_req", {31'b0, imem_req}, 0);
        chk("rst dmem_req", {31'b0, dmem_req}, 0);
        chk("rst dmem_we", {31'b0, dmem_we}, 0);
        chk("rst dmem_be", {28'b0, dmem_be}, 0);
        chk("rst retire", {31'b0, retire}, 0);
        chk("rst halted", {31'b0, halted}, 0);
        chk("rst trap", {30'b0, trap_cause}, 0);
        chk("rst pc", pc_out, 32'h0);
        chk("rst ir", instr_out, 32'h0000_0013);
        reset_dut();
        run_to_halt(200, "t1");
        chk("t1 x2 stored", dmem[16], 32'hFFFF_FFFE);
        chk("t1 alu gap", ret_cyc[rb+1] - ret_cyc[rb], 3);
        chk("t1 store gap", ret_cyc[rb+2] - ret_cyc[rb+1], 4);
        chk("t1 pc 3rd", ret_pc[rb+2], 32'h8);
        chk("t1 retires", nret - rb, 3);
        chk("t1 trap", {30'b0, trap_cause}, 3);
        chk("t1 halt pc", pc_out, 32'hC);
        chk("t1 halt no req", {31'b0, imem_req}, 0);

        // Test 2: sw/lw loop, zero-wait then random waits.
        prog_loop();
        reset_dut();
        run_to_halt(500, "t2z");
        chk_loop("t2z");
        rand_wait = 1;
        reset_dut();
        run_to_halt(3000, "t2r");
        chk_loop("t2r");
        rand_wait = 0;

        // Test 3: byte store lanes and signed/unsigned byte loads.
        fill_imem();
        imem[0] = addi(5'd5, 5'd0, 32'hA5);
        imem[1] = s_t(32'h103, 5'd5, 5'd0, 3'd0);
        imem[2] = i_t(32'h103, 5'd0, 3'd0, 5'd6, 7'h03);
        imem[3] = i_t(32'h103, 5'd0, 3'd4, 5'd7, 7'h03);
        imem[4] = s_t(32'h80, 5'd6, 5'd0, 3'd2);
        imem[5] = s_t(32'h84, 5'd7, 5'd0, 3'd2);
        imem[6] = ECALL;
        reset_dut();
        run_to_halt(300, "t3");
        chk("t3 sb we", {31'b0, tx_we[xb]}, 1);
        chk("t3 sb be", {28'b0, tx_be[xb]}, 32'h8);
        chk("t3 sb wdata", tx_wd[xb], 32'hA5A5_A5A5);
        chk("t3 sb addr", tx_addr[xb], 32'h100);
        chk("t3 lb be", {28'b0, tx_be[xb+1]}, 32'h8);
        chk("t3 lb we", {31'b0, tx_we[xb+1]}, 0);
        chk("t3 mem word", dmem[64], 32'hA500_0000);
        chk("t3 lb", dmem[32], 32'hFFFF_FFA5);
        chk("t3 lbu", dmem[33], 32'h0000_00A5);

        // Test 4: misaligned lw traps without a bus request; illegal opcode.
        fill_imem();
        imem[0] = addi(5'd1, 5'd0, 32'h100);
        imem[1] = i_t(2, 5'd1, 3'd2, 5'd2, 7'h03);
        reset_dut();
        run_to_halt(100, "t4");
        repeat (5) @(negedge clk);
        chk("t4 trap", {30'b0, trap_cause}, 2);
        chk("t4 pc frozen", pc_out, 32'h4);
        chk("t4 no dmem_req", dreq_cyc - db, 0);
        chk("t4 no imem_req", {31'b0, imem_req}, 0);
        fill_imem();
        reset_dut();
        run_to_halt(100, "t4b");
        chk("t4b trap", {30'b0, trap_cause}, 1);
        chk("t4b pc", pc_out, 32'h0);

        // Test 5: backward beq, jal link, jalr clears bit 0.
        fill_imem();
        imem[0]  = addi(5'd3, 5'd0, 0);
        imem[1]  = j_t(32'h14, 5'd0);
        imem[4]  = addi(5'd3, 5'd3, 1);
        imem[5]  = j_t(32'hC, 5'd0);
        imem[6]  = b_t(-8, 5'd0, 5'd0, 3'd0);
        imem[8]  = j_t(16, 5'd1);
        imem[12] = s_t(32'h90, 5'd1, 5'd0, 3'd2);
        imem[13] = s_t(32'h94, 5'd3, 5'd0, 3'd2);
        imem[14] = addi(5'd4, 5'd0, 32'h41);
        imem[15] = i_t(0, 5'd4, 3'd0, 5'd5, 7'h67);
        imem[16] = s_t(32'h98, 5'd5, 5'd0, 3'd2);
        imem[17] = ECALL;
        reset_dut();
        run_to_halt(400, "t5");
        chk("t5 beq target", ret_pc[rb+3], 32'h10);
        chk("t5 jal pc", ret_pc[rb+5], 32'h20);
        chk("t5 after jal", ret_pc[rb+6], 32'h30);
        chk("t5 x1 link", dmem[36], 32'h24);
        chk("t5 x3", dmem[37], 32'h1);
        chk("t5 jalr link", dmem[38], 32'h40);
        chk("t5 halt pc", pc_out, 32'h44);
        chk("t5 trap", {30'b0, trap_cause}, 3);

        // Test 6: reset during a data wait, late ack ignored, clean restart.
        prog_loop();
        dwait_fix = 5;
        reset_dut();
        begin
            int n = 0;
            while (!dmem_req && n < 200) begin @(negedge clk); n++; end
        end
        chk("t6 reached mem", {31'b0, dmem_req}, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6 dmem_req drop", {31'b0, dmem_req}, 0);
        chk("t6 imem_req drop", {31'b0, imem_req}, 0);
        @(negedge clk);
        force_dack = 1'b1;
        @(negedge clk);
        rb = nret; db = dreq_cyc; gb = glitch;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6 restart pc", pc_out, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("t6 late ack no req", {31'b0, dmem_req}, 0);
        end
        force_dack = 1'b0;
        run_to_halt(800, "t6");
        chk("t6 first retire pc", ret_pc[rb], 32'h0);
        chk_loop("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
